// File: rtl/cpu55_mem_pkg.sv
// Shared memory-interface types for the CPU data path: access sizes, LSU states and the
// default data_ram address width.
package cpu55_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 20;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_chk.sv
// Combinational size/alignment/range check; yields the error flag and the one-hot
// word/half/byte strobes. Shared with the instruction-fetch path.
module lsu_align_chk
  import cpu55_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  output logic        o_err,
  output logic        o_w,
  output logic        o_h,
  output logic        o_b
);

  logic w_range_err;

  // Any address bit above the RAM's address width is out of range.
  assign w_range_err = ((i_addr >> ADDR_W) != 32'd0);

  always_comb begin
    o_w   = 1'b0;
    o_h   = 1'b0;
    o_b   = 1'b0;
    o_err = w_range_err;
    unique case (size_e'(i_size))
      SZ_BYTE: o_b = 1'b1;
      SZ_HALF: begin
        o_h   = 1'b1;
        o_err = w_range_err | i_addr[0];
      end
      SZ_WORD: begin
        o_w   = 1'b1;
        o_err = w_range_err | (i_addr[1:0] != 2'b00);
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and data_ram: one request at a time,
// registered RAM strobes, read-latency wait, single-cycle response and BadVAddr capture.
module lsu_ctrl
  import cpu55_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       bad_vaddr,
  output logic              ram_ena,
  output logic              wena,
  output logic              w,
  output logic              h,
  output logic              b,
  output logic              z,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out,
  input  logic              AddressError
);

  lsu_state_e r_state, w_state_d;

  logic              w_accept;
  logic              w_chk_err, w_chk_w, w_chk_h, w_chk_b;
  logic              r_ram_ena, r_wena, r_w, r_h, r_b, r_z;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data_in;
  logic [31:0]       r_req_addr;
  logic              r_we;
  logic [1:0]        r_cnt;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [31:0]       r_bad_vaddr;

  lsu_align_chk #(
    .ADDR_W (ADDR_W)
  ) u_align_chk (
    .i_size (req_size),
    .i_addr (req_addr),
    .o_err  (w_chk_err),
    .o_w    (w_chk_w),
    .o_h    (w_chk_h),
    .o_b    (w_chk_b)
  );

  assign w_accept = req_valid && (r_state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = w_chk_err ? StResp : StAccess;
      StAccess: w_state_d = (AddressError || r_we) ? StResp : StWait;
      StWait:   if (r_cnt == 2'd1) w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_ena    <= 1'b0;
      r_wena       <= 1'b0;
      r_w          <= 1'b0;
      r_h          <= 1'b0;
      r_b          <= 1'b0;
      r_z          <= 1'b0;
      r_addr       <= '0;
      r_data_in    <= '0;
      r_req_addr   <= '0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_bad_vaddr  <= '0;
    end else begin
      // Strobes are live only for the single ACCESS cycle; addr/data_in hold.
      r_ram_ena <= 1'b0;
      r_wena    <= 1'b0;
      r_w       <= 1'b0;
      r_h       <= 1'b0;
      r_b       <= 1'b0;
      r_z       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_chk_err) begin
            r_bad_vaddr  <= req_addr;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else if (w_accept) begin
            r_ram_ena  <= 1'b1;
            r_wena     <= req_we;
            r_w        <= w_chk_w;
            r_h        <= w_chk_h;
            r_b        <= w_chk_b;
            r_z        <= req_unsigned & ~req_we;
            r_addr     <= req_addr[ADDR_W-1:0];
            r_data_in  <= req_wdata;
            r_req_addr <= req_addr;
            r_we       <= req_we;
          end
        end
        StAccess: begin
          if (AddressError) begin
            r_bad_vaddr  <= r_req_addr;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else if (r_we) begin
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= 2'(RD_LAT);
          end
        end
        StWait: begin
          if (r_cnt == 2'd1) begin
            r_resp_rdata <= data_out;
            r_resp_err   <= 1'b0;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == StIdle);
  assign resp_valid = (r_state == StResp);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign bad_vaddr  = r_bad_vaddr;
  assign ram_ena    = r_ram_ena;
  assign wena       = r_wena;
  assign w          = r_w;
  assign h          = r_h;
  assign b          = r_b;
  assign z          = r_z;
  assign addr       = r_addr;
  assign data_in    = r_data_in;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store initiator that sits between the CPU datapath and the data_ram: accepts one memory request at a time from the execute stage over a valid/ready handshake and drives data_ram's ram_ena/wena/w/h/b/z/addr/data_in strobes. It also waits out the RAM read latency, captures data_out and returns a single-cycle response. It pre-checks alignment and range so illegal requests never reach the RAM. On error it latches the faulting address for the exception unit (BadVAddr).

Parameters:
ADDR_W, 20, width of the data_ram addr port; request addresses with bits [31:ADDR_W] nonzero are out of range.
RD_LAT, 1, data_ram read latency in clock edges after the access cycle; legal range 1..3.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  high only in IDLE; a transfer occurs when req_valid && req_ready at a rising edge
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends (drives z); ignored for stores
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  qualified by resp_valid: misaligned, out of range, illegal size, or RAM AddressError
bad_vaddr  output  32  faulting address, updated only on error
ram_ena  output  1  to data_ram
wena  output  1  to data_ram
w  output  1  to data_ram, word strobe
h  output  1  to data_ram, half strobe
b  output  1  to data_ram, byte strobe
z  output  1  to data_ram, zero-extend select
addr  output  ADDR_W  to data_ram
data_in  output  32  to data_ram
data_out  input  32  from data_ram
AddressError  input  1  from data_ram

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All outputs are 0 except req_ready = 1; this includes ram_ena, wena, w, h, b, z, addr, data_in, resp_*, and bad_vaddr.
  - Reset mid-operation abandons the request. No resp_valid is produced for it, and ram_ena drops without waiting for an edge.
- All RAM-side outputs are registered. When not in ACCESS: ram_ena = wena = w = h = b = z = 0; addr and data_in hold their last values.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE, on accept at edge E0, check the request:
  - err if req_size == 11;
  - err if size == half and addr[0];
  - err if size == word and addr[1:0] != 0;
  - err if addr[31:ADDR_W] != 0.
- IDLE -> RESP on err:
  - resp_valid = 1 and resp_err = 1 in the cycle after E0.
  - bad_vaddr = req_addr.
  - No RAM access is made.
- IDLE -> ACCESS otherwise:
  - For the one cycle after E0: ram_ena = 1, wena = req_we, exactly one of w/h/b set, z = req_unsigned & ~req_we, addr = req_addr[ADDR_W-1:0], data_in = req_wdata.
  - The request is latched internally, so the req_* inputs may change after E0.
- ACCESS, edge E1: sample AddressError.
  - If AddressError is set: go to RESP with err; bad_vaddr = latched address.
  - Store: go to RESP with resp_err = 0 (resp_valid in the cycle after E1).
  - Load: go to WAIT with counter = RD_LAT.
- WAIT: decrement the counter each edge. When it reaches 0, capture data_out into resp_rdata and go to RESP.
  - Load with RD_LAT = 1: resp_valid in the cycle after E2.
- RESP: resp_valid is high for exactly one cycle, then IDLE.
  - req_ready returns to 1 the cycle after RESP, so back-to-back throughput is one request per 3 cycles (stores) or 3+RD_LAT cycles (loads).
  - resp_rdata and resp_err hold until the next RESP.
- There is no response backpressure; the consumer must take resp_valid when it pulses.
- req_valid outside IDLE is ignored (req_ready = 0).

Decomposition:
- Shared package cpu55_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings;
  - ADDR_W default.
- Natural sub-module: lsu_align_chk, a purely combinational size/alignment/range check producing err and the one-hot w/h/b. It is reused by the instruction-fetch path.

Test Plan:
1. Store word 0x000000d4 to 980, then load word from 980 -> ram strobe cycle shows ram_ena=1, wena=1, w=1, addr=980, data_in=0xd4. Load returns resp_rdata=0x000000d4 and resp_err=0, with resp_valid 3 cycles after accept.
2. Store byte 0x80 to 7, then load byte signed and then unsigned from 7 -> signed load returns 0xFFFFFF80 (z=0); unsigned load returns 0x00000080 (z=1).
3. Load word at 1010 and store half at 5 -> no ram_ena pulse for either; resp_err=1 one cycle after accept; bad_vaddr=1010, then 5.
4. req_addr=0x00100000 (bit 20 set) and req_size=11 -> resp_err=1, no RAM access, bad_vaddr updated each time.
5. Tie the data_ram AddressError model to 1 during a word store to 1008 -> ram_ena pulses once; resp_err=1; bad_vaddr=1008.
6. Assert rst during WAIT of a load (RD_LAT=3) -> ram_ena=0 and resp_valid=0 immediately, req_ready=1. After release, a store to 1008 completes normally with resp_err=0.
